fft2d_sequencer: RTL and testbench

- Sequences a 2-D FFT of an IMG×IMG complex image through the shared R4MDC_Top core (N-point, WL-bit).
- Owns an IMG×IMG frame buffer. Flow: load the image from the host stream, run a row pass (results written back in place), then run a column pass (results streamed out).
- Drives the core's burst Start protocol and collects its done-qualified outputs. Sits between the image source/sink and the FFT core.

---
 rtl/fft2d_sequencer_if.sv | 30 +++
 rtl/fft2d_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_fft2d_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft2d_sequencer_if.sv
// Stream and FFT-core signal bundle for fft2d_sequencer.
// master: the sequencer's view. slave: the host/core side.
interface fft2d_sequencer_if #(
  parameter int unsigned WL = 10
) ();
  // Host input stream
  logic              s_valid;
  logic              s_ready;
  logic [2*WL-1:0]   s_data;
  // FFT core
  logic              fft_start;
  logic [2*WL-1:0]   fft_in;
  logic              fft_done;
  logic [WL-1:0]     fft_out_r;
  logic [WL-1:0]     fft_out_i;
  // Column-pass result stream
  logic              m_valid;
  logic [2*WL-1:0]   m_data;
  logic              m_last;

  modport master (
    input  s_valid, s_data, fft_done, fft_out_r, fft_out_i,
    output s_ready, fft_start, fft_in, m_valid, m_data, m_last
  );

  modport slave (
    output s_valid, s_data, fft_done, fft_out_r, fft_out_i,
    input  s_ready, fft_start, fft_in, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fft2d_sequencer.sv
// 2-D FFT sequencer: loads an IMG x IMG complex image into a frame buffer, runs a
// row pass through the shared FFT core (results written back in place), then a
// column pass whose results are streamed out on m_*.
// Optional macro FFT2D_ROW_DUMP_EN adds dbg_valid/dbg_data, mirroring every
// captured row-pass word one cycle after fft_done.
module fft2d_sequencer #(
  parameter int unsigned WL  = 10,
  parameter int unsigned N   = 16,
  parameter int unsigned IMG = 80,
  parameter int unsigned GAP = 24,
  parameter int unsigned AW  = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic               busy,
  output logic               done,
  output logic               err,
  fft2d_sequencer_if.master  bus
`ifdef FFT2D_ROW_DUMP_EN
  ,
  output logic               dbg_valid,
  output logic [2*WL-1:0]    dbg_data
`endif
);

  localparam int unsigned P   = IMG * IMG;
  localparam int unsigned F   = P / N;
  localparam int unsigned Per = N + GAP;
  localparam int unsigned PcW = (Per > 1) ? $clog2(Per) : 1;
  localparam int unsigned BcW = $clog2(F + 1);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned IW  = (IMG > 1) ? $clog2(IMG) : 1;
  localparam int unsigned DW  = 2 * WL;

  localparam logic [CW-1:0]  NumSamples = CW'(P);
  localparam logic [CW-1:0]  LastSample = CW'(P - 1);
  localparam logic [BcW-1:0] LastBurst  = BcW'(F - 1);
  localparam logic [PcW-1:0] PcStartLen = PcW'(N);
  localparam logic [PcW-1:0] PcLastHigh = PcW'(N - 1);
  localparam logic [PcW-1:0] PcLast     = PcW'(Per - 1);
  localparam logic [IW-1:0]  LastRow    = IW'(IMG - 1);
  localparam logic [AW-1:0]  RowStride  = AW'(IMG);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRow,
    StRowDrain,
    StCol,
    StColDrain
  } state_e;

  state_e          r_state;
  logic [PcW-1:0]  r_pc;        // position within the burst period
  logic [BcW-1:0]  r_bc;        // bursts issued in the current pass
  logic [AW-1:0]   r_k;         // row-pass read address
  logic [AW-1:0]   r_cb;        // column-pass row base, IMG*p
  logic [IW-1:0]   r_p;         // column-pass row index
  logic [AW-1:0]   r_m;         // column-pass column index
  logic [CW-1:0]   r_wa;        // load write address
  logic [CW-1:0]   r_h;         // row-pass capture address
  logic [CW-1:0]   r_o;         // column-pass output count

  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_s_ready;
  logic            r_fft_start;
  logic [DW-1:0]   r_fft_in;
  logic            r_m_valid;
  logic [DW-1:0]   r_m_data;
  logic            r_m_last;
`ifdef FFT2D_ROW_DUMP_EN
  logic            r_dbg_valid;
  logic [DW-1:0]   r_dbg_data;
`endif

  logic [DW-1:0]   r_mem [2**AW];

  logic [AW-1:0]   w_ra;
  logic [DW-1:0]   w_rd_word;
  logic [DW-1:0]   w_out_word;
  logic            w_s_acc;
  logic            w_cap_row;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_wa;
  logic [DW-1:0]   w_mem_wd;

  // Read address, accept strobes and the single buffer write port mux.
  always_comb begin
    w_out_word = {bus.fft_out_r, bus.fft_out_i};
    w_s_acc    = bus.s_valid & r_s_ready;
    w_ra       = (r_state == StCol) ? (r_cb + r_m) : r_k;
    w_cap_row  = bus.fft_done & ((r_state == StRow) | (r_state == StRowDrain)) &
                 (r_h < NumSamples);
    w_mem_we   = 1'b0;
    w_mem_wa   = '0;
    w_mem_wd   = '0;
    if (w_s_acc) begin
      w_mem_we = 1'b1;
      w_mem_wa = r_wa[AW-1:0];
      w_mem_wd = bus.s_data;
    end else if (w_cap_row) begin
      // In-place write trails the read pointer by the core latency, so no collision.
      w_mem_we = 1'b1;
      w_mem_wa = r_h[AW-1:0];
      w_mem_wd = w_out_word;
    end
  end

  assign w_rd_word = r_mem[w_ra];

  // Frame buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_wa] <= w_mem_wd;
    end
  end

  // Sequencer FSM: load, burst scheduling, capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pc        <= '0;
      r_bc        <= '0;
      r_k         <= '0;
      r_cb        <= '0;
      r_p         <= '0;
      r_m         <= '0;
      r_wa        <= '0;
      r_h         <= '0;
      r_o         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_s_ready   <= 1'b0;
      r_fft_start <= 1'b0;
      r_fft_in    <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
`ifdef FFT2D_ROW_DUMP_EN
      r_dbg_valid <= 1'b0;
      r_dbg_data  <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
`ifdef FFT2D_ROW_DUMP_EN
      r_dbg_valid <= 1'b0;
`endif

      unique case (r_state)
        StIdle: begin
          r_fft_start <= 1'b0;
          if (go) begin
            r_state   <= StLoad;
            r_busy    <= 1'b1;
            r_s_ready <= 1'b1;
            r_err     <= 1'b0;
            r_pc      <= '0;
            r_bc      <= '0;
            r_k       <= '0;
            r_cb      <= '0;
            r_p       <= '0;
            r_m       <= '0;
            r_wa      <= '0;
            r_h       <= '0;
            r_o       <= '0;
          end
        end

        StLoad: begin
          r_fft_start <= 1'b0;
          if (w_s_acc) begin
            r_wa <= r_wa + 1'b1;
            if (r_wa == LastSample) begin
              r_state   <= StRow;
              r_s_ready <= 1'b0;
            end
          end
        end

        StRow, StCol: begin
          if (r_pc < PcStartLen) begin
            r_fft_start <= 1'b1;
            r_fft_in    <= w_rd_word;
            if (r_state == StRow) begin
              r_k <= r_k + 1'b1;
            end else if (r_p == LastRow) begin
              r_p  <= '0;
              r_cb <= '0;
              r_m  <= r_m + 1'b1;
            end else begin
              r_p  <= r_p + 1'b1;
              r_cb <= r_cb + RowStride;
            end
          end else begin
            r_fft_start <= 1'b0;
          end
          r_pc <= (r_pc == PcLast) ? '0 : r_pc + 1'b1;
          if (r_pc == PcLastHigh) begin
            r_bc <= r_bc + 1'b1;
            if (r_bc == LastBurst) begin
              r_state <= (r_state == StRow) ? StRowDrain : StColDrain;
            end
          end
        end

        StRowDrain: begin
          r_fft_start <= 1'b0;
          if (r_h == NumSamples) begin
            r_state <= StCol;
            r_pc    <= '0;
            r_bc    <= '0;
            r_k     <= '0;
            r_cb    <= '0;
            r_p     <= '0;
            r_m     <= '0;
          end
        end

        StColDrain: begin
          r_fft_start <= 1'b0;
          if (r_o == NumSamples) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: r_state <= StIdle;
      endcase

      // Core output capture; anything unexpected is dropped and flagged.
      if (bus.fft_done) begin
        unique case (r_state)
          StRow, StRowDrain: begin
            if (r_h < NumSamples) begin
              r_h <= r_h + 1'b1;
`ifdef FFT2D_ROW_DUMP_EN
              r_dbg_valid <= 1'b1;
              r_dbg_data  <= w_out_word;
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
          StCol, StColDrain: begin
            if (r_o < NumSamples) begin
              r_m_valid <= 1'b1;
              r_m_data  <= w_out_word;
              r_m_last  <= (r_o == LastSample);
              r_o       <= r_o + 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: r_err <= 1'b1;
        endcase
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign bus.s_ready   = r_s_ready;
  assign bus.fft_start = r_fft_start;
  assign bus.fft_in    = r_fft_in;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = r_m_data;
  assign bus.m_last    = r_m_last;
`ifdef FFT2D_ROW_DUMP_EN
  assign dbg_valid     = r_dbg_valid;
  assign dbg_data      = r_dbg_data;
`endif

endmodule

// File: tb/tb_fft2d_sequencer.sv
// Directed bench for fft2d_sequencer: a small instance (IMG=16, N=16) for data,
// abort and error scenarios and a default-parameter instance for burst timing.
// Both cores are modelled as identity with a 20-cycle latency.
module tb_fft2d_sequencer;
  localparam int unsigned Wl   = 10;
  localparam int unsigned Dw   = 20;
  localparam int unsigned SImg = 16;
  localparam int unsigned SP   = 256;
  localparam int unsigned BImg = 80;
  localparam int unsigned BP   = 6400;
  localparam int unsigned Lat  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, go, busy, done, err;
  logic go_b, busy_b, done_b, err_b;
  logic inj;

  fft2d_sequencer_if #(.WL(Wl)) sif ();
  fft2d_sequencer_if #(.WL(Wl)) bif ();

`ifdef FFT2D_ROW_DUMP_EN
  logic          dbg_valid, dbg_valid_b;
  logic [Dw-1:0] dbg_data, dbg_data_b;
`endif

  fft2d_sequencer #(.WL(Wl), .N(16), .IMG(SImg), .GAP(24), .AW(8)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .busy (busy),
    .done (done),
    .err  (err),
    .bus  (sif.master)
`ifdef FFT2D_ROW_DUMP_EN
    ,
    .dbg_valid (dbg_valid),
    .dbg_data  (dbg_data)
`endif
  );

  fft2d_sequencer u_big (
    .clk  (clk),
    .rst  (rst),
    .go   (go_b),
    .busy (busy_b),
    .done (done_b),
    .err  (err_b),
    .bus  (bif.master)
`ifdef FFT2D_ROW_DUMP_EN
    ,
    .dbg_valid (dbg_valid_b),
    .dbg_data  (dbg_data_b)
`endif
  );

  // Identity core models, flushed by rst.
  logic          s_dv [Lat];
  logic [Dw-1:0] s_dd [Lat];
  logic          b_dv [Lat];
  logic [Dw-1:0] b_dd [Lat];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Lat; i++) begin
        s_dv[i] <= 1'b0;
        b_dv[i] <= 1'b0;
      end
    end else begin
      s_dv[0] <= sif.fft_start;
      s_dd[0] <= sif.fft_in;
      b_dv[0] <= bif.fft_start;
      b_dd[0] <= bif.fft_in;
      for (int i = 1; i < Lat; i++) begin
        s_dv[i] <= s_dv[i-1];
        s_dd[i] <= s_dd[i-1];
        b_dv[i] <= b_dv[i-1];
        b_dd[i] <= b_dd[i-1];
      end
    end
  end

  assign sif.fft_done  = s_dv[Lat-1] | inj;
  assign sif.fft_out_r = s_dd[Lat-1][Dw-1:Wl];
  assign sif.fft_out_i = s_dd[Lat-1][Wl-1:0];
  assign bif.fft_done  = b_dv[Lat-1];
  assign bif.fft_out_r = b_dd[Lat-1][Dw-1:Wl];
  assign bif.fft_out_i = b_dd[Lat-1][Wl-1:0];

  // Small-instance stream recorders.
  logic [Dw-1:0] q_fin [$];
  logic [Dw-1:0] q_m   [$];
  logic [Dw-1:0] q_dbg [$];
  int n_last = 0, last_idx = -1, n_done = 0;

  always @(negedge clk) begin
    if (sif.fft_start) q_fin.push_back(sif.fft_in);
    if (sif.m_valid) begin
      if (sif.m_last) begin
        n_last++;
        last_idx = q_m.size();
      end
      q_m.push_back(sif.m_data);
    end
    if (done) n_done++;
`ifdef FFT2D_ROW_DUMP_EN
    if (dbg_valid) q_dbg.push_back(dbg_data);
`endif
  end

  // Large-instance recorders: Start run lengths, rise times, words, outputs.
  int b_cyc = 0, b_run = 0, b_nlast = 0, b_last_idx = -1, b_ndone = 0;
  logic b_prev = 1'b0;
  int b_hi [$];
  int b_rise [$];
  logic [Dw-1:0] b_fin [$];
  logic [Dw-1:0] b_m [$];

  always @(negedge clk) begin
    b_cyc++;
    if (bif.fft_start) begin
      b_fin.push_back(bif.fft_in);
      if (!b_prev) b_rise.push_back(b_cyc);
      b_run++;
    end else if (b_prev) begin
      b_hi.push_back(b_run);
      b_run = 0;
    end
    b_prev = bif.fft_start;
    if (bif.m_valid) begin
      if (bif.m_last) begin
        b_nlast++;
        b_last_idx = b_m.size();
      end
      b_m.push_back(bif.m_data);
    end
    if (done_b) b_ndone++;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel i of an img x img image: {row+100, col}.
  function automatic logic [Dw-1:0] pix(input int img, input int i);
    return {Wl'(i / img + 100), Wl'(i % img)};
  endfunction

  // Expected column-pass word j: buffer index img*(j%img) + j/img.
  function automatic logic [Dw-1:0] colpix(input int img, input int j);
    return pix(img, img * (j % img) + j / img);
  endfunction

  task automatic clr_small;
    @(posedge clk);
    #1;
    q_fin.delete();
    q_m.delete();
    q_dbg.delete();
    n_last = 0;
    last_idx = -1;
    n_done = 0;
  endtask

  task automatic pulse_go;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic load_small(input bit rev);
    int i = 0;
    int guard = 0;
    while (i < SP && guard < 4 * SP) begin
      @(negedge clk);
      guard++;
      sif.s_valid = 1'b1;
      sif.s_data  = pix(SImg, rev ? SP - 1 - i : i);
      if (sif.s_ready) i++;
    end
    @(negedge clk);
    sif.s_valid = 1'b0;
    chk("small load words", i, SP);
  endtask

  task automatic load_big;
    int i = 0;
    int guard = 0;
    while (i < BP && guard < 2 * BP) begin
      @(negedge clk);
      guard++;
      bif.s_valid = 1'b1;
      bif.s_data  = pix(BImg, i);
      if (bif.s_ready) i++;
    end
    @(negedge clk);
    bif.s_valid = 1'b0;
    chk("big load words", i, BP);
  endtask

  task automatic wait_small_done(input int budget);
    int c = 0;
    while (n_done == 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("small done within budget", 32'(n_done != 0), 1);
  endtask

  task automatic check_col_small(input string tag);
    chk({tag, " m count"}, q_m.size(), SP);
    for (int j = 0; j < SP; j++) begin
      chk($sformatf("%s m_data[%0d]", tag, j), q_m[j], colpix(SImg, j));
    end
    chk({tag, " m_last count"}, n_last, 1);
    chk({tag, " m_last index"}, last_idx, SP - 1);
  endtask

  initial begin
    int c;
    int bad_hi, bad_gap, bad_fin, bad_m;
    rst = 1'b1;
    go = 1'b0;
    go_b = 1'b0;
    inj = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    bif.s_valid = 1'b0;
    bif.s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset s_ready", sif.s_ready, 0);
    chk("reset fft_start", sif.fft_start, 0);
    chk("reset fft_in", sif.fft_in, 0);
    chk("reset m_valid", sif.m_valid, 0);
    chk("reset m_data", sif.m_data, 0);
    chk("reset m_last", sif.m_last, 0);

    // fft_done in IDLE flags err; accepted go clears it
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("idle fft_done err", err, 1);
    chk("idle fft_done busy", busy, 0);
    clr_small();
    pulse_go();
    chk("go clears err", err, 0);
    chk("go busy", busy, 1);
    chk("go s_ready", sif.s_ready, 1);

    // Full transform on the 16x16 instance
    load_small(1'b0);
    chk("s_ready low after load", sif.s_ready, 0);
    wait_small_done(4000);
    repeat (5) @(negedge clk);
    chk("t1 fft_in count", q_fin.size(), 2 * SP);
    for (int j = 0; j < SP; j++) begin
      chk($sformatf("t1 row fft_in[%0d]", j), q_fin[j], pix(SImg, j));
    end
    for (int j = 0; j < SP; j++) begin
      chk($sformatf("t1 col fft_in[%0d]", j), q_fin[SP + j], colpix(SImg, j));
    end
    check_col_small("t1");
    chk("t1 done pulses", n_done, 1);
    chk("t1 err", err, 0);
    chk("t1 busy after done", busy, 0);
`ifdef FFT2D_ROW_DUMP_EN
    chk("t1 dbg count", q_dbg.size(), SP);
    for (int j = 0; j < SP; j++) begin
      chk($sformatf("t1 dbg_data[%0d]", j), q_dbg[j], pix(SImg, j));
    end
`endif

    // Reset 50 cycles into the row pass, then a clean transform
    clr_small();
    pulse_go();
    load_small(1'b1);
    repeat (50) @(negedge clk);
    chk("t3 busy before abort", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t3 abort busy", busy, 0);
    chk("t3 abort fft_start", sif.fft_start, 0);
    chk("t3 abort fft_in", sif.fft_in, 0);
    chk("t3 abort s_ready", sif.s_ready, 0);
    chk("t3 abort m_valid", sif.m_valid, 0);
    chk("t3 abort done", done, 0);
    chk("t3 abort err", err, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t3 no done on abort", n_done, 0);
    clr_small();
    pulse_go();
    load_small(1'b0);
    wait_small_done(4000);
    repeat (5) @(negedge clk);
    check_col_small("t3");
    chk("t3 done pulses", n_done, 1);
    chk("t3 err", err, 0);

    // An extra column-pass output is dropped and flagged
    clr_small();
    pulse_go();
    load_small(1'b0);
    c = 0;
    while (!(sif.m_valid && sif.m_last) && c < 4000) begin
      @(negedge clk);
      c++;
    end
    chk("t5 m_last reached", 32'(sif.m_valid && sif.m_last), 1);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("t5 done with extra", done, 1);
    chk("t5 extra m_valid", sif.m_valid, 0);
    repeat (5) @(negedge clk);
    chk("t5 m count", q_m.size(), SP);
    chk("t5 err", err, 1);
    chk("t5 done pulses", n_done, 1);
    chk("t5 busy", busy, 0);

    // Default parameters: burst timing and data
    @(negedge clk);
    go_b = 1'b1;
    @(negedge clk);
    go_b = 1'b0;
    load_big();
    c = 0;
    while (b_ndone == 0 && c < 40000) begin
      @(negedge clk);
      c++;
    end
    chk("t2 done within budget", 32'(b_ndone != 0), 1);
    repeat (5) @(negedge clk);
    bad_hi = 0;
    bad_gap = 0;
    bad_fin = 0;
    bad_m = 0;
    foreach (b_hi[r]) if (b_hi[r] != 16) bad_hi++;
    for (int r = 1; r < b_rise.size(); r++) begin
      if (r != 400 && (b_rise[r] - b_rise[r-1]) != 40) bad_gap++;
    end
    for (int j = 0; j < b_fin.size(); j++) begin
      if (j < BP) begin
        if (b_fin[j] !== pix(BImg, j)) bad_fin++;
      end else if (b_fin[j] !== colpix(BImg, j - BP)) bad_fin++;
    end
    for (int j = 0; j < b_m.size(); j++) begin
      if (b_m[j] !== colpix(BImg, j)) bad_m++;
    end
    chk("t2 burst count", b_hi.size(), 800);
    chk("t2 rise count", b_rise.size(), 800);
    chk("t2 start-high not 16", bad_hi, 0);
    chk("t2 period not 40", bad_gap, 0);
    chk("t2 fft_in count", b_fin.size(), 2 * BP);
    chk("t2 fft_in wrong words", bad_fin, 0);
    chk("t2 m count", b_m.size(), BP);
    chk("t2 m_data wrong words", bad_m, 0);
    chk("t2 m_last count", b_nlast, 1);
    chk("t2 m_last index", b_last_idx, BP - 1);
    chk("t2 done pulses", b_ndone, 1);
    chk("t2 err", err_b, 0);
    chk("t2 busy", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
